dtcm_lsu: RTL
=============

Name: dtcm_lsu

Overview:
- Load/store unit between the pipeline MEM stage and the word-addressed data TCM.
- Accepts byte/halfword/word loads and stores over a valid/ready request channel.
- The TCM has no byte enables, so byte and halfword stores are done as read-modify-write.
- Drives the TCM read and write ports from an FSM and returns sign- or zero-extended load data on a valid/ready response channel.

Parameters:
- AW, 4, TCM word-address width; the TCM holds 2^AW words.
- DW, 32, data width. Only 32 is supported.

Ports:
- CLK  in  1  single clock; also drives the TCM WCLK and RCLK.
- RST_N  in  1  asynchronous reset, active-low.
- REQ_VALID  in  1  request valid.
- REQ_READY  out  1  request ready.
- REQ_WE  in  1  1 = store, 0 = load.
- REQ_FUNCT3  in  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- REQ_ADDR  in  32  byte address.
- REQ_WDATA  in  32  store data, right-aligned.
- RSP_VALID  out  1  response valid.
- RSP_READY  in  1  response ready.
- RSP_RDATA  out  32  extended load data; 0 for stores.
- RSP_ERR  out  1  misaligned or out-of-range access.
- TCM_WADDR  out  AW  TCM write word address.
- TCM_WDATA  out  32  TCM write data.
- TCM_WEN  out  1  TCM write enable.
- TCM_RADDR  out  AW  TCM read word address.
- TCM_RDATA  in  32  TCM read data; combinational, and Z when TCM_REN=0.
- TCM_REN  out  1  TCM read enable.

Behaviour:
- Reset values: state IDLE; REQ_READY=1; RSP_VALID=0; RSP_RDATA=0; RSP_ERR=0; TCM_WEN=0; TCM_REN=0; address/data outputs 0.
- Reset is asynchronous; asserting it mid-operation aborts immediately. WEN/REN drop in the same instant, so no partial or merged write ever reaches the TCM.
- FSM states: IDLE, RD, WR, RSP.
  - IDLE: REQ_READY=1. On REQ_VALID, latch WE, FUNCT3, ADDR, WDATA.
    - Error check fails -> RSP with RSP_ERR=1.
    - Load, or store with FUNCT3 B/H -> RD.
    - Store W -> WR.
  - RD: TCM_REN=1, TCM_RADDR=ADDR[AW+1:2]; capture TCM_RDATA into a buffer. Load -> RSP; subword store -> WR.
  - WR: TCM_WEN=1, TCM_WADDR=ADDR[AW+1:2]; TCM_WDATA = buffered word with the target lane replaced.
    - B: lane ADDR[1:0] <- WDATA[7:0].
    - H: lane ADDR[1] <- WDATA[15:0].
    - W: WDATA.
    - Then -> RSP.
  - RSP: RSP_VALID=1; outputs held stable until RSP_READY=1; then -> IDLE. REQ_READY=0 in RD, WR and RSP.
- A new request is accepted only in IDLE, so a request cannot be accepted in the same cycle as the response handshake (1-cycle bubble).
- Latency from the accept cycle (cycle 0) to RSP_VALID:
  - Load: cycle 2.
  - SW: cycle 2.
  - SB/SH: cycle 3.
  - Error response: cycle 1.
- Load extraction: byte lane ADDR[1:0] or halfword lane ADDR[1].
  - B/H: sign-extend.
  - BU/HU: zero-extend.
  - W: pass through.
- TCM_REN is high only in RD. The Z value on TCM_RDATA outside RD is never sampled.
- Error conditions (with LSU_ERR_EN):
  - H/HU with ADDR[0]=1.
  - W with ADDR[1:0]!=0.
  - ADDR[31:AW+2]!=0.
  - Illegal FUNCT3 (011, 110, 111, or a store with 100/101).
  - An errored access never asserts TCM_WEN or TCM_REN.
- Back-to-back RMW: a load issued after SB to the same word returns the merged value (the write completes before the next accept).

Optional Feature:
- Macro LSU_ERR_EN.
- Defined: error checks as above; RSP_ERR is a registered output.
- Undefined:
  - No checks; RSP_ERR is tied 0.
  - Misaligned low bits are forced aligned for H/W: ADDR[0] ignored for H, ADDR[1:0] ignored for W.
  - Upper address bits are ignored.
  - Illegal FUNCT3 is treated as W.

Test Plan:
- Reset, then SW 0xDEADBEEF @0x8, then LW @0x8 -> TCM_WEN pulses once with WADDR=2; load RSP_RDATA=0xDEADBEEF at cycle 2 after accept.
- Word @0x4 = 0x11223344; SB 0xAA @0x6 -> one RD cycle then one WR cycle with TCM_WDATA=0x11AA3344; RSP_VALID at cycle 3.
- Word = 0x80FF7F01; LB @+3 -> 0xFFFFFF80; LBU @+3 -> 0x00000080; LH @+2 -> 0xFFFF80FF; LHU @+0 -> 0x00007F01.
- With LSU_ERR_EN: LW @0x5 and SW @0x40 (AW=4) -> RSP_ERR=1 at cycle 1, TCM_WEN/TCM_REN never asserted, memory unchanged.
- Hold RSP_READY=0 for 5 cycles after a load -> RSP_VALID/RSP_RDATA stable and REQ_READY=0 throughout; the next request is accepted the cycle after the handshake.
- Assert RST_N=0 during the WR state of an SH -> TCM_WEN falls immediately, the target word keeps its old value, and outputs return to reset values.

Source files
------------

// File: rtl/dtcm_lsu.sv
// dtcm_lsu: byte/half/word load-store unit in front of a word-addressed data TCM without byte enables.
// Sub-word stores are read-modify-write. Define LSU_ERR_EN to enable misalign/range/funct3 error responses.
module dtcm_lsu #(
    parameter int AW = 4,
    parameter int DW = 32
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          REQ_VALID,
    output logic          REQ_READY,
    input  logic          REQ_WE,
    input  logic [2:0]    REQ_FUNCT3,
    input  logic [31:0]   REQ_ADDR,
    input  logic [DW-1:0] REQ_WDATA,
    output logic          RSP_VALID,
    input  logic          RSP_READY,
    output logic [DW-1:0] RSP_RDATA,
    output logic          RSP_ERR,
    output logic [AW-1:0] TCM_WADDR,
    output logic [DW-1:0] TCM_WDATA,
    output logic          TCM_WEN,
    output logic [AW-1:0] TCM_RADDR,
    input  logic [DW-1:0] TCM_RDATA,
    output logic          TCM_REN
);
    typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;

    state_t        state_q, state_d;
    logic          we_q, we_d;
    logic [1:0]    sz_q, sz_d;          // 0 byte, 1 half, 2 word
    logic          uns_q, uns_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d, buf_q, buf_d, rdata_q, rdata_d;
    logic          err_q, err_d;

    logic          illegal, req_err;
    logic [1:0]    req_sz;
    logic [7:0]    ld_b;
    logic [15:0]   ld_h;
    logic [DW-1:0] ld_ext, st_merge;

    always_comb begin
        illegal = (REQ_FUNCT3[1:0] == 2'b11) || (REQ_FUNCT3[2] && (REQ_FUNCT3[1] || REQ_WE));
        req_sz  = illegal ? 2'd2 : REQ_FUNCT3[1:0];
    end

`ifdef LSU_ERR_EN
    assign req_err = illegal
                  || (req_sz == 2'd1 && REQ_ADDR[0])
                  || (req_sz == 2'd2 && REQ_ADDR[1:0] != 2'b00)
                  || (REQ_ADDR[31:AW+2] != '0);
`else
    // Without checks the upper address bits alias onto the TCM; low bits are ignored by lane selection.
    logic unused_addr;
    assign unused_addr = ^REQ_ADDR[31:AW+2];
    assign req_err     = 1'b0;
`endif

    always_comb begin
        ld_b = TCM_RDATA[{addr_q[1:0], 3'b000} +: 8];
        ld_h = TCM_RDATA[{addr_q[1], 4'b0000} +: 16];
        case (sz_q)
            2'd0:    ld_ext = uns_q ? {24'd0, ld_b} : {{24{ld_b[7]}}, ld_b};
            2'd1:    ld_ext = uns_q ? {16'd0, ld_h} : {{16{ld_h[15]}}, ld_h};
            default: ld_ext = TCM_RDATA;
        endcase
    end

    always_comb begin
        st_merge = buf_q;
        case (sz_q)
            2'd0:    st_merge[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'd1:    st_merge[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: st_merge = wdata_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        sz_d    = sz_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        buf_d   = buf_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (REQ_VALID) begin
                we_d    = REQ_WE;
                sz_d    = req_sz;
                uns_d   = REQ_FUNCT3[2];
                addr_d  = REQ_ADDR[AW+1:0];
                wdata_d = REQ_WDATA;
                rdata_d = '0;
                err_d   = req_err;
                if (req_err)                      state_d = RSP;
                else if (REQ_WE && req_sz == 2'd2) state_d = WR;
                else                              state_d = RD;
            end
            RD: begin
                buf_d = TCM_RDATA;
                if (we_q) state_d = WR;
                else begin
                    rdata_d = ld_ext;
                    state_d = RSP;
                end
            end
            WR:      state_d = RSP;
            RSP:     if (RSP_READY) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            sz_q    <= 2'd0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            buf_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            sz_q    <= sz_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            buf_q   <= buf_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Strobes decode straight from the state register so an async reset kills them at once.
    assign REQ_READY = (state_q == IDLE);
    assign RSP_VALID = (state_q == RSP);
    assign RSP_RDATA = rdata_q;
    assign RSP_ERR   = err_q;
    assign TCM_REN   = (state_q == RD);
    assign TCM_WEN   = (state_q == WR);
    assign TCM_RADDR = TCM_REN ? addr_q[AW+1:2] : '0;
    assign TCM_WADDR = TCM_WEN ? addr_q[AW+1:2] : '0;
    assign TCM_WDATA = TCM_WEN ? st_merge : '0;

endmodule
